ysyx_23060096_ifu: RTL and testbench



---
 rtl/ysyx_23060096_ifu_if.sv | 22 ++
 rtl/ysyx_23060096_ifu.sv | 75 +++++++
 tb/tb_ysyx_23060096_ifu.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060096_ifu_if.sv
// ysyx_23060096_ifu_if: fetch request, response, decoder and redirect signals of the IFU.
interface ysyx_23060096_ifu_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  modport master (
    output req_valid, req_addr, inst_valid, inst, inst_pc,
    input  req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  req_valid, req_addr, inst_valid, inst, inst_pc,
    output req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_23060096_ifu.sv
// ysyx_23060096_ifu: credit-based prefetching fetch unit; define YSYX_23060096_IFU_BYPASS_EN for the resp->inst bypass.
module ysyx_23060096_ifu #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              DEPTH    = 4
) (
  input logic clk,
  input logic rst,
  ysyx_23060096_ifu_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  logic [XLEN-1:0] fetch_pc, resp_pc, new_pc;
  logic [CW-1:0]   inflight, inflight_nx, drop, count;
  logic [AW-1:0]   head, tail;
  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [XLEN-1:0] q_inst [DEPTH];
  logic            empty, fire, resp_ok, keep, byp, enq, deq;
  always_comb begin
    empty       = count == '0;
    fire        = bus.req_valid && bus.req_ready;
    resp_ok     = bus.resp_valid && inflight != '0;
    keep        = resp_ok && drop == '0;
`ifdef YSYX_23060096_IFU_BYPASS_EN
    byp         = empty && keep && !bus.redirect_valid;
`else
    byp         = 1'b0;
`endif
    deq         = !empty && bus.inst_ready;
    enq         = keep && !(byp && bus.inst_ready);
    inflight_nx = inflight + CW'(fire) - CW'(resp_ok);
    new_pc      = bus.redirect_pc & ~XLEN'(3);
    bus.req_valid  = !rst && ({1'b0, count} + {1'b0, inflight} < SW'(DEPTH));
    bus.req_addr   = fetch_pc;
    bus.inst_valid = !empty || byp;
    bus.inst       = !empty ? q_inst[head] : byp ? bus.resp_data : '0;
    bus.inst_pc    = !empty ? q_pc[head]   : byp ? resp_pc       : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= inflight_nx;
      if (bus.redirect_valid) begin
        // everything still outstanding after this edge, including a request fired now, is stale
        fetch_pc <= new_pc;
        resp_pc  <= new_pc;
        drop     <= inflight_nx;
        count    <= '0;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (keep) resp_pc <= resp_pc + XLEN'(4);
        if (resp_ok && drop != '0) drop <= drop - CW'(1);
        if (enq) tail <= tail + AW'(1);
        if (deq) head <= head + AW'(1);
        count <= count + CW'(enq) - CW'(deq);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      q_pc[tail]   <= resp_pc;
      q_inst[tail] <= bus.resp_data;
    end
  end
endmodule

// File: tb/tb_ysyx_23060096_ifu.sv
// tb_ysyx_23060096_ifu: scoreboard bench with a latency-programmable in-order memory model.
module tb_ysyx_23060096_ifu;
  localparam int          XLEN   = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] PAT    = 32'hA5A5_0000;
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
    bit          orphan;
  } mreq_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ysyx_23060096_ifu_if #(.XLEN(XLEN)) bus();
  ysyx_23060096_ifu #(.XLEN(XLEN), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  mreq_t       mem_q[$];
  logic [63:0] sb[$];
  logic [31:0] deq_log[$];
  logic [31:0] exp_pc = RST_PC;
  int          cyc, lat = 1, fire_cnt, vectors, miscompares;
  bit          resp_en = 1'b1;
  task automatic step();
    int live;
    bit exp_rv, fire, rsp, usable, byp, exp_iv, took;
    logic [63:0] e, g;
    bus.resp_valid = resp_en && mem_q.size() > 0 && mem_q[0].due <= cyc;
    bus.resp_data  = bus.resp_valid ? (mem_q[0].addr ^ PAT) : '0;
    @(negedge clk);
    live = 0;
    foreach (mem_q[i]) if (!mem_q[i].orphan) live++;
    exp_rv = !rst && (sb.size() + live < DEPTH);
    vectors++;
    if (bus.req_valid !== exp_rv) begin
      miscompares++;
      $display("FAIL req_valid cyc %0d: got %b want %b", cyc, bus.req_valid, exp_rv);
    end
    if (exp_rv) begin
      vectors++;
      if (bus.req_addr !== exp_pc) begin
        miscompares++;
        $display("FAIL req_addr cyc %0d: got %h want %h", cyc, bus.req_addr, exp_pc);
      end
    end
    fire   = exp_rv && bus.req_ready;
    rsp    = bus.resp_valid;
    usable = rsp && !rst && !mem_q[0].stale && !mem_q[0].orphan;
`ifdef YSYX_23060096_IFU_BYPASS_EN
    byp = usable && sb.size() == 0 && !bus.redirect_valid;
`else
    byp = 1'b0;
`endif
    took = 1'b0;
    if (!rst) begin
      exp_iv = sb.size() > 0 || byp;
      vectors++;
      if (bus.inst_valid !== exp_iv) begin
        miscompares++;
        $display("FAIL inst_valid cyc %0d: got %b want %b", cyc, bus.inst_valid, exp_iv);
      end
      if (exp_iv && bus.inst_ready) begin
        if (sb.size() > 0) e = sb.pop_front();
        else begin
          e = {mem_q[0].addr, mem_q[0].addr ^ PAT};
          took = 1'b1;
        end
        g = {bus.inst_pc, bus.inst};
        deq_log.push_back(g[63:32]);
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL dequeue cyc %0d: got pc/inst %h want %h", cyc, g, e);
        end
      end
    end
    if (usable && !took) sb.push_back({mem_q[0].addr, mem_q[0].addr ^ PAT});
    if (rsp) void'(mem_q.pop_front());
    if (fire) begin
      mem_q.push_back('{exp_pc, cyc + lat, 1'b0, 1'b0});
      exp_pc += 32'd4;
      fire_cnt++;
    end
    if (rst) begin
      foreach (mem_q[i]) mem_q[i].orphan = 1'b1;
      sb.delete();
      exp_pc = RST_PC;
    end else if (bus.redirect_valid) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      sb.delete();
      exp_pc = bus.redirect_pc & ~32'd3;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic drain();
    bus.req_ready = 1'b0;
    bus.inst_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    for (int k = 0; k < 60 && (mem_q.size() > 0 || sb.size() > 0); k++) step();
    vectors++;
    if (mem_q.size() != 0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain timeout: got %0d/%0d pending want 0/0", mem_q.size(), sb.size());
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.req_ready = 1'b0;
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    vectors += 3;
    if (bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset inst_valid: got %b want 0", bus.inst_valid); end
    if ({bus.inst, bus.inst_pc} !== 64'd0) begin miscompares++; $display("FAIL reset inst/inst_pc: got %h %h want 0 0", bus.inst, bus.inst_pc); end
    if (bus.req_addr !== RST_PC) begin miscompares++; $display("FAIL reset req_addr: got %h want %h", bus.req_addr, RST_PC); end
  endtask
  task automatic test_stream();
    int want;
`ifdef YSYX_23060096_IFU_BYPASS_EN
    want = 19;
`else
    want = 18;
`endif
    lat = 1;
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    deq_log.delete();
    for (int k = 0; k < 20; k++) step();
    vectors++;
    if (deq_log.size() != want) begin
      miscompares++;
      $display("FAIL stream throughput: got %0d want %0d", deq_log.size(), want);
    end
    drain();
  endtask
  task automatic test_backpressure();
    int f0 = fire_cnt;
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b0;
    for (int k = 0; k < 10; k++) step();
    vectors += 2;
    if (fire_cnt - f0 != DEPTH) begin miscompares++; $display("FAIL backpressure requests: got %0d want %0d", fire_cnt - f0, DEPTH); end
    if (bus.req_valid !== 1'b0) begin miscompares++; $display("FAIL backpressure req_valid: got %b want 0", bus.req_valid); end
    bus.req_ready = 1'b0;
    bus.inst_ready = 1'b1;
    deq_log.delete();
    for (int k = 0; k < 8; k++) step();
    vectors++;
    if (deq_log.size() != DEPTH) begin miscompares++; $display("FAIL backpressure drained: got %0d want %0d", deq_log.size(), DEPTH); end
    drain();
  endtask
  task automatic test_redirect();
    lat = 3;
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b0;
    step();
    step();
    bus.req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h8000_0102;
    step();
    bus.redirect_valid = 1'b0;
    vectors++;
    if (bus.req_addr !== 32'h8000_0100) begin miscompares++; $display("FAIL redirect req_addr: got %h want 80000100", bus.req_addr); end
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    deq_log.delete();
    for (int k = 0; k < 20 && deq_log.size() == 0; k++) step();
    vectors++;
    if (deq_log.size() == 0 || deq_log[0] !== 32'h8000_0100) begin
      miscompares++;
      $display("FAIL redirect first pc: got %h want 80000100", deq_log.size() ? deq_log[0] : 32'hx);
    end
    drain();
    lat = 1;
  endtask
  task automatic test_redirect_collide();
    lat = 2;
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h8000_2000;
    step();
    bus.redirect_pc = 32'h8000_3001;
    step();
    bus.redirect_valid = 1'b0;
    deq_log.delete();
    for (int k = 0; k < 12; k++) step();
    vectors++;
    if (deq_log.size() == 0 || deq_log[0] !== 32'h8000_3000) begin
      miscompares++;
      $display("FAIL collide first pc: got %h want 80003000", deq_log.size() ? deq_log[0] : 32'hx);
    end
    drain();
    lat = 1;
  endtask
  task automatic test_wrap();
    bus.req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    deq_log.delete();
    for (int k = 0; k < 6; k++) step();
    vectors++;
    if (deq_log.size() < 2 || deq_log[0] !== 32'hFFFF_FFFC || deq_log[1] !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap pcs: got %h %h want fffffffc 00000000",
               deq_log.size() > 0 ? deq_log[0] : 32'hx, deq_log.size() > 1 ? deq_log[1] : 32'hx);
    end
    drain();
  endtask
  task automatic test_reset_mid();
    lat = 1;
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b0;
    for (int k = 0; k < 20 && !(sb.size() == 3 && mem_q.size() == 1); k++) step();
    vectors++;
    if (!(sb.size() == 3 && mem_q.size() == 1)) begin
      miscompares++;
      $display("FAIL reset_mid setup: got count %0d inflight %0d want 3 1", sb.size(), mem_q.size());
    end
    rst = 1'b1;
    bus.req_ready = 1'b0;
    resp_en = 1'b0;
    step();
    rst = 1'b0;
    resp_en = 1'b1;
    #1;
    vectors += 2;
    if (bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mid inst_valid: got %b want 0", bus.inst_valid); end
    if (bus.req_addr !== RST_PC) begin miscompares++; $display("FAIL reset_mid req_addr: got %h want %h", bus.req_addr, RST_PC); end
    step();
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    deq_log.delete();
    for (int k = 0; k < 6; k++) step();
    vectors++;
    if (deq_log.size() == 0 || deq_log[0] !== RST_PC) begin
      miscompares++;
      $display("FAIL reset_mid first pc: got %h want %h", deq_log.size() ? deq_log[0] : 32'hx, RST_PC);
    end
    drain();
  endtask
  initial begin
    bus.resp_valid = 1'b0;
    bus.resp_data = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_collide();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
